// File: rtl/mini_alu_pipe.sv
// mini_alu_pipe: 3-stage fetch/decode/execute mini-ALU core with Execute->Decode forwarding,
// branch squash, halt and freeze; register file internal, instruction ROM external.
module mini_alu_pipe #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int IP_W   = 16,
    parameter int LED_W  = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iEnable,
    output logic [IP_W-1:0]       oIP,
    input  logic [4+3*ADDR_W-1:0] iInstruction,
    output logic [LED_W-1:0]      oLed,
    output logic                  oHalted
);
    localparam int IW = 4 + 3*ADDR_W;
    logic [DATA_W-1:0] rf_q [2**ADDR_W];
    logic [IP_W-1:0] ip_q, ip_d, tgt;
    logic [IW-1:0] d_q, d_d, e_q, e_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res;
    logic [LED_W-1:0] led_q, led_d;
    logic halted_q, halted_d;
    logic [3:0] e_op;
    logic [ADDR_W-1:0] e_dst, d_s1, d_s0;
    logic [2*ADDR_W-1:0] imm;
    logic wr, taken, hlt, run;
    assign e_op  = e_q[IW-1 -: 4];
    assign e_dst = e_q[3*ADDR_W-1 -: ADDR_W];
    assign imm   = e_q[2*ADDR_W-1:0];
    assign d_s1  = d_q[2*ADDR_W-1 -: ADDR_W];
    assign d_s0  = d_q[ADDR_W-1:0];
    assign tgt   = IP_W'(e_dst);
    assign run   = iEnable && !halted_q;
    assign wr    = (e_op >= 4'd1 && e_op <= 4'd4) || (e_op >= 4'd8 && e_op <= 4'd12);
    assign taken = e_op == 4'd6 || (e_op == 4'd5 && a_q <= b_q) || (e_op == 4'd13 && a_q == b_q);
    assign hlt   = e_op == 4'd14;
    assign oIP     = ip_q;
    assign oLed    = led_q;
    assign oHalted = halted_q;
    always_comb begin
        res = e_op == 4'd1  ? a_q + b_q :
              e_op == 4'd2  ? a_q - b_q :
              e_op == 4'd3  ? a_q * b_q :
              e_op == 4'd4  ? DATA_W'(imm) :
              e_op == 4'd8  ? a_q & b_q :
              e_op == 4'd9  ? a_q | b_q :
              e_op == 4'd10 ? a_q ^ b_q :
              e_op == 4'd11 ? a_q << b_q :
              e_op == 4'd12 ? a_q >> b_q : '0;
    end
    // Decode captures operands; a write pending in Execute overrides the stale RF value.
    always_comb begin
        ip_d     = ip_q;
        d_d      = d_q;
        e_d      = e_q;
        a_d      = a_q;
        b_d      = b_q;
        led_d    = led_q;
        halted_d = halted_q;
        if (run) begin
            ip_d     = hlt ? ip_q : taken ? tgt : ip_q + 1'b1;
            d_d      = (hlt || taken) ? '0 : iInstruction;
            e_d      = (hlt || taken) ? '0 : d_q;
            a_d      = (wr && e_dst == d_s1) ? res : rf_q[d_s1];
            b_d      = (wr && e_dst == d_s0) ? res : rf_q[d_s0];
            led_d    = e_op == 4'd7 ? a_q[LED_W-1:0] : led_q;
            halted_d = hlt;
        end
    end
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            ip_q     <= '0;
            d_q      <= '0;
            e_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            led_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            ip_q     <= ip_d;
            d_q      <= d_d;
            e_q      <= e_d;
            a_q      <= a_d;
            b_q      <= b_d;
            led_q    <= led_d;
            halted_q <= halted_d;
        end
    end
    always_ff @(posedge Clock) begin
        if (Reset && run && wr) rf_q[e_dst] <= res;
    end
endmodule

// File: tb/tb_mini_alu_pipe.sv
// tb_mini_alu_pipe: directed and randomized programs checked cycle by cycle against an
// instruction-level model with a simple retire-time rule.
module tb_mini_alu_pipe;
    localparam int NC = 400;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n, en, halted, rst_w, halted_w;
    logic [15:0] ip, led;
    logic [27:0] ins, ins_w;
    logic [9:0] ip_w;
    logic [7:0] led_w;
    logic [27:0] rom [256];
    logic [27:0] prog [$];
    logic [15:0] exp_ip [NC+1];
    logic [15:0] exp_led [NC+1];
    logic exp_h [NC+1];
    int total = 0, bad = 0;
    assign ins   = rom[ip[7:0]];
    assign ins_w = ip_w == 10'h3FF ? {4'd14, 24'd0} : 28'd0;

    mini_alu_pipe #(.DATA_W(16), .ADDR_W(8), .IP_W(16), .LED_W(16)) dut (
        .Clock(clk), .Reset(rst_n), .iEnable(en), .oIP(ip),
        .iInstruction(ins), .oLed(led), .oHalted(halted));

    mini_alu_pipe #(.DATA_W(16), .ADDR_W(8), .IP_W(10), .LED_W(8)) dut_w (
        .Clock(clk), .Reset(rst_w), .iEnable(1'b1), .oIP(ip_w),
        .iInstruction(ins_w), .oLed(led_w), .oHalted(halted_w));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [27:0] mk(input int op, input int d, input int s1, input int s0);
        return {op[3:0], d[7:0], s1[7:0], s0[7:0]};
    endfunction

    function automatic logic [27:0] sto(input int d, input int imm);
        return mk(4, d, imm >> 8, imm & 255);
    endfunction

    // Architectural model: first instruction retires on posedge 3, then one per cycle,
    // a taken branch delays its target by 3, HLT ends execution.
    function automatic void model(input int ncyc);
        logic [15:0] r [256];
        int ev_k [NC+1];
        int ev_v [NC+1];
        logic [27:0] w;
        logic [15:0] pc, ipm, ledm;
        logic hm;
        int t, op, d, s1, s0, a, b;
        for (int i = 0; i <= NC; i++) begin
            ev_k[i] = 0;
            ev_v[i] = 0;
        end
        t = 3;
        pc = 0;
        while (t <= ncyc) begin
            w = rom[pc[7:0]];
            op = int'(w[27:24]);
            d = int'(w[23:16]);
            s1 = int'(w[15:8]);
            s0 = int'(w[7:0]);
            a = int'(r[s1]);
            b = int'(r[s0]);
            if (op == 14) begin
                ev_k[t] = 3;
                break;
            end
            if (op == 6 || (op == 5 && a <= b) || (op == 13 && a == b)) begin
                ev_k[t] = 2;
                ev_v[t] = d;
                pc = 16'(d);
                t += 3;
                continue;
            end
            case (op)
                1: r[d] = 16'(a + b);
                2: r[d] = 16'(a - b);
                3: r[d] = 16'(a * b);
                4: r[d] = 16'(s1 * 256 + s0);
                7: begin
                    ev_k[t] = 1;
                    ev_v[t] = a;
                end
                8: r[d] = 16'(a & b);
                9: r[d] = 16'(a | b);
                10: r[d] = 16'(a ^ b);
                11: r[d] = b >= 16 ? 16'd0 : 16'(a << b);
                12: r[d] = b >= 16 ? 16'd0 : 16'(a >> b);
                default: ;
            endcase
            pc++;
            t++;
        end
        ipm = 0;
        ledm = 0;
        hm = 0;
        exp_ip[0] = 0;
        exp_led[0] = 0;
        exp_h[0] = 0;
        for (int k = 1; k <= ncyc; k++) begin
            if (!hm) begin
                if (ev_k[k] == 2) ipm = 16'(ev_v[k]);
                else if (ev_k[k] == 3) hm = 1;
                else ipm++;
                if (ev_k[k] == 1) ledm = 16'(ev_v[k]);
            end
            exp_ip[k] = ipm;
            exp_led[k] = ledm;
            exp_h[k] = hm;
        end
    endfunction

    task automatic run(input int ncyc, input int frz_pct, input int frz_at);
        int cnt = 0, hold = 0;
        for (int i = 0; i < 256; i++) rom[i] = i < prog.size() ? prog[i] : 28'd0;
        prog.delete();
        model(ncyc);
        rst_n = 1'b0;
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ip", 32'(ip), 0);
        check("rst_led", 32'(led), 0);
        check("rst_halt", 32'(halted), 0);
        rst_n = 1'b1;
        while (cnt < ncyc) begin
            if (cnt == frz_at && hold < 3) begin
                en = 1'b0;
                hold++;
            end else en = $urandom_range(99) >= frz_pct;
            @(posedge clk);
            if (en) cnt++;
            #1;
            check("ip", 32'(ip), 32'(exp_ip[cnt]));
            check("led", 32'(led), 32'(exp_led[cnt]));
            check("halt", 32'(halted), 32'(exp_h[cnt]));
        end
        en = 1'b1;
    endtask

    initial begin
        int n, op, d, s1, s0;
        rst_n = 1'b0;
        rst_w = 1'b0;
        en = 1'b1;
        // HLT at the last address: IP wraps before the halt retires, then freezes.
        repeat (2) @(posedge clk);
        #1;
        check("w_rst_ip", 32'(ip_w), 0);
        rst_w = 1'b1;
        n = 0;
        while (!halted_w && n < 1200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("w_cycles", n, 1026);
        check("w_halt", 32'(halted_w), 1);
        check("w_ip", 32'(ip_w), 1);
        repeat (3) @(posedge clk);
        #1;
        check("w_ip_hold", 32'(ip_w), 1);
        check("w_led", 32'(led_w), 0);
        rst_w = 1'b0;
        @(posedge clk);
        #1;
        check("w_rst_ip2", 32'(ip_w), 0);
        check("w_rst_halt2", 32'(halted_w), 0);

        prog = '{sto(1, 5), sto(2, 3), mk(1, 3, 1, 2), mk(7, 0, 3, 0)};
        run(12, 0, -1);
        check("t1_led", 32'(led), 8);

        prog = '{sto(1, 7), mk(1, 1, 1, 1), mk(1, 1, 1, 1), mk(7, 0, 1, 0)};
        run(12, 0, -1);
        check("t2_led", 32'(led), 28);

        prog = '{sto(1, 2), sto(2, 9), sto(4, 'h11), sto(5, 'h22), mk(5, 'h10, 1, 2),
                 sto(4, 'hAA), sto(5, 'hBB)};
        while (prog.size() < 16) prog.push_back(28'd0);
        prog.push_back(mk(1, 6, 4, 5));
        prog.push_back(mk(7, 0, 6, 0));
        run(20, 0, -1);
        check("t3_led", 32'(led), 'h33);

        prog = '{sto(1, 1), sto(2, 15), mk(11, 4, 1, 2), mk(7, 0, 4, 0)};
        run(10, 0, -1);
        check("t4_shl15", 32'(led), 'h8000);
        prog = '{sto(1, 1), sto(3, 16), mk(7, 0, 1, 0), mk(11, 4, 1, 3), mk(7, 0, 4, 0)};
        run(10, 0, -1);
        check("t4_shl16", 32'(led), 0);
        prog = '{sto(1, 3), sto(2, 5), mk(2, 3, 1, 2), mk(7, 0, 3, 0)};
        run(10, 0, -1);
        check("t4_sub", 32'(led), 'hFFFE);
        prog = '{sto(1, 'h100), mk(7, 0, 1, 0), mk(3, 3, 1, 1), mk(7, 0, 3, 0)};
        run(10, 0, -1);
        check("t4_mul", 32'(led), 0);
        prog = '{sto(1, 'h8000), sto(2, 15), mk(12, 3, 1, 2), mk(7, 0, 3, 0)};
        run(10, 0, -1);
        check("t4_shr", 32'(led), 1);

        prog = '{sto(1, 5), sto(2, 6), mk(1, 3, 1, 2), mk(7, 0, 3, 0)};
        run(14, 0, 4);
        check("t5_led", 32'(led), 11);

        prog = '{mk(6, 8, 0, 0), mk(6, 12, 0, 0), 28'd0, 28'd0, 28'd0, 28'd0, 28'd0, 28'd0,
                 sto(1, 'h55), mk(7, 0, 1, 0), mk(14, 0, 0, 0), 28'd0,
                 sto(1, 'h66), mk(7, 0, 1, 0)};
        run(16, 0, -1);
        check("sq_led", 32'(led), 'h55);
        check("sq_halt", 32'(halted), 1);

        for (int p = 0; p < 25; p++) begin
            for (int i = 0; i < 8; i++)
                prog.push_back(sto(i, $urandom_range(1) ? $urandom_range(31) : $urandom_range(65535)));
            for (int i = 0; i < 48; i++) begin
                op = $urandom_range(15);
                if (op == 14) op = $urandom_range(15);
                d = (op == 5 || op == 6 || op == 13) ? $urandom_range(63) : $urandom_range(7);
                s1 = op == 4 ? $urandom_range(255) : $urandom_range(7);
                s0 = op == 4 ? $urandom_range(255) : $urandom_range(7);
                prog.push_back(mk(op, d, s1, s0));
            end
            run(300, 20, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
